mem_arbiter: RTL and testbench

- Memory-side responder for the pipelined datapath.
- Arbitrates fetch requests (iREN/iaddr) and MEM-stage data requests (dREN/dWEN/daddr/dstore) onto one single-ported RAM.
- Generates the ihit/dhit strobes that the pipeline latches use to advance or to clear MEM controls.
- Data requests have priority over fetches: the MEM-stage instruction is older and stalls the whole pipe.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Memory-side arbiter: puts MEM-stage data requests and instruction fetches onto one
// single-ported RAM. Data requests win. Produces the ihit/dhit strobes and a sticky err flag.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] imemload,
  output logic [WORD_W-1:0] dmemload,
  output logic              ram_REN,
  output logic              ram_WEN,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              ren_nxt, wen_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [WORD_W-1:0] store_nxt;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_REN   <= 1'b0;
      ram_WEN   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ram_REN   <= ren_nxt;
      ram_WEN   <= wen_nxt;
      ram_addr  <= addr_nxt;
      ram_store <= store_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ren_nxt   = ram_REN;
    wen_nxt   = ram_WEN;
    addr_nxt  = ram_addr;
    store_nxt = ram_store;
    err_nxt   = err;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // ram_addr doubles as the latched request address for the ihit match.
        if (dREN | dWEN) begin
          state_nxt = DACC;
          ren_nxt   = ~dWEN;
          wen_nxt   = dWEN;
          addr_nxt  = daddr;
          store_nxt = dstore;
          if (dREN & dWEN) err_nxt = 1'b1;
        end else if (iREN) begin
          state_nxt = IACC;
          ren_nxt   = 1'b1;
          wen_nxt   = 1'b0;
          addr_nxt  = iaddr;
        end
      end
      DACC, IACC: begin
        if (ram_ready) begin
          state_nxt = IDLE;
          ren_nxt   = 1'b0;
          wen_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_nxt = IDLE;
          ren_nxt   = 1'b0;
          wen_nxt   = 1'b0;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        ren_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Hits require the requester to still want the same access when the RAM answers.
  assign dhit     = (state == DACC) & ram_ready & (dREN | dWEN);
  assign ihit     = (state == IACC) & ram_ready & iREN & (iaddr == ram_addr);
  assign dmemload = (state == DACC) ? ram_load : '0;
  assign imemload = (state == IACC) ? ram_load : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the bench plays the RAM and scores hits from a queue.
module tb_mem_arbiter;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ram_load;
  logic        ihit, dhit, ram_REN, ram_WEN, err;
  logic [31:0] imemload, dmemload, ram_addr, ram_store;

  mem_arbiter #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .imemload(imemload),
    .dmemload(dmemload), .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    bit          has_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input bit is_d, input bit has_data, input logic [31:0] d);
    exp_t e;
    e.is_d     = is_d;
    e.has_data = has_data;
    e.data     = d;
    sb.push_back(e);
  endtask

  task automatic check_hit(input string tag);
    exp_t e;
    chk({tag, "_sbsize"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_hit"},   e.is_d ? 64'(dhit) : 64'(ihit), 64'd1);
      chk({tag, "_other"}, e.is_d ? 64'(ihit) : 64'(dhit), 64'd0);
      if (e.has_data)
        chk({tag, "_data"}, e.is_d ? 64'(dmemload) : 64'(imemload), 64'(e.data));
    end
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
    cyc(); cyc();
    chk("rst_ren", 64'(ram_REN), 0);
    chk("rst_wen", 64'(ram_WEN), 0);
    chk("rst_addr", 64'(ram_addr), 0);
    chk("rst_store", 64'(ram_store), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_hits", 64'({ihit, dhit}), 0);
    RST = 1'b0;

    // Fetch only
    cyc(); iREN = 1; iaddr = 32'h40; #1;
    chk("f_w0_ren", 64'(ram_REN), 0);
    cyc(); #1;
    chk("f_w1_ren", 64'(ram_REN), 1);
    chk("f_w1_addr", 64'(ram_addr), 64'h40);
    chk("f_w1_wen", 64'(ram_WEN), 0);
    cyc(); #1;
    chk("f_w2_ihit", 64'(ihit), 0);
    chk("f_w2_ren", 64'(ram_REN), 1);
    cyc(); ram_ready = 1; ram_load = 32'h2402000A; push_exp(0, 1, 32'h2402000A); #1;
    check_hit("f_w3");
    cyc(); ram_ready = 0; iREN = 0; #1;
    chk("f_w4_ren", 64'(ram_REN), 0);
    chk("f_w4_imem", 64'(imemload), 0);

    // Contention: data first, fetch after the IDLE cycle
    cyc(); iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; #1;
    cyc(); #1;
    chk("c_w1_addr", 64'(ram_addr), 64'h100);
    chk("c_w1_ren", 64'(ram_REN), 1);
    cyc(); ram_ready = 1; ram_load = 32'h11112222; push_exp(1, 1, 32'h11112222); #1;
    check_hit("c_w2");
    cyc(); ram_ready = 0; dREN = 0; #1;
    chk("c_w3_idle_ren", 64'(ram_REN), 0);
    cyc(); #1;
    chk("c_w4_ren", 64'(ram_REN), 1);
    chk("c_w4_addr", 64'(ram_addr), 64'h44);
    cyc(); ram_ready = 1; ram_load = 32'h33334444; push_exp(0, 1, 32'h33334444); #1;
    check_hit("c_w5");
    cyc(); ram_ready = 0; iREN = 0; #1;

    // Redirect mid-fetch
    cyc(); iREN = 1; iaddr = 32'h40; #1;
    cyc(); #1;
    chk("r_w1_addr", 64'(ram_addr), 64'h40);
    cyc(); iaddr = 32'h80; #1;
    cyc(); ram_ready = 1; ram_load = 32'h00000BAD; #1;
    chk("r_w3_noihit", 64'(ihit), 0);
    cyc(); ram_ready = 0; #1;
    chk("r_w4_ren", 64'(ram_REN), 0);
    cyc(); #1;
    chk("r_w5_ren", 64'(ram_REN), 1);
    chk("r_w5_addr", 64'(ram_addr), 64'h80);
    cyc(); ram_ready = 1; ram_load = 32'h0C0FFEE0; push_exp(0, 1, 32'h0C0FFEE0); #1;
    check_hit("r_w6");
    cyc(); ram_ready = 0; iREN = 0; #1;

    // Write
    cyc(); dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF; #1;
    cyc(); #1;
    chk("w_w1_wen", 64'(ram_WEN), 1);
    chk("w_w1_ren", 64'(ram_REN), 0);
    chk("w_w1_addr", 64'(ram_addr), 64'h200);
    chk("w_w1_store", 64'(ram_store), 64'hDEADBEEF);
    cyc(); #1;
    chk("w_w2_wen", 64'(ram_WEN), 1);
    chk("w_w2_dhit", 64'(dhit), 0);
    cyc(); ram_ready = 1; push_exp(1, 0, '0); #1;
    check_hit("w_w3");
    cyc(); ram_ready = 0; dWEN = 0; #1;
    chk("w_w4_dhit", 64'(dhit), 0);
    chk("w_w4_wen", 64'(ram_WEN), 0);
    chk("w_w4_err", 64'(err), 0);

    // Data request withdrawn mid-access
    cyc(); dREN = 1; daddr = 32'h300; #1;
    cyc(); #1;
    chk("x_w1_ren", 64'(ram_REN), 1);
    cyc(); dREN = 0; ram_ready = 1; ram_load = 32'h55AA55AA; #1;
    chk("x_w2_nodhit", 64'(dhit), 0);
    cyc(); ram_ready = 0; #1;
    chk("x_w3_ren", 64'(ram_REN), 0);

    // dREN & dWEN together: write plus err
    cyc(); dREN = 1; dWEN = 1; daddr = 32'h500; dstore = 32'h12345678; #1;
    chk("b_w0_err", 64'(err), 0);
    cyc(); #1;
    chk("b_w1_wen", 64'(ram_WEN), 1);
    chk("b_w1_ren", 64'(ram_REN), 0);
    chk("b_w1_store", 64'(ram_store), 64'h12345678);
    chk("b_w1_err", 64'(err), 1);
    cyc(); ram_ready = 1; push_exp(1, 0, '0); #1;
    check_hit("b_w2");
    cyc(); ram_ready = 0; dREN = 0; dWEN = 0; #1;
    chk("b_w3_err", 64'(err), 1);

    // Reset during DACC
    cyc(); dREN = 1; daddr = 32'h600; #1;
    cyc(); #1;
    chk("z_w1_ren", 64'(ram_REN), 1);
    cyc(); ram_ready = 1; ram_load = 32'hFFFF0000; RST = 1; #1;
    chk("z_ren", 64'(ram_REN), 0);
    chk("z_addr", 64'(ram_addr), 0);
    chk("z_dhit", 64'(dhit), 0);
    chk("z_dmem", 64'(dmemload), 0);
    chk("z_err", 64'(err), 0);
    cyc(); RST = 0; dREN = 0; ram_ready = 0; #1;

    // ram_ready while idle is ignored
    cyc(); ram_ready = 1; #1;
    chk("i_hits", 64'({ihit, dhit}), 0);
    cyc(); ram_ready = 0; #1;
    chk("i_ren", 64'(ram_REN), 0);

    // Timeout: 15 waiting cycles then abort
    cyc(); dREN = 1; daddr = 32'h400; #1;
    for (int i = 1; i <= 15; i++) begin
      cyc(); #1;
      if (i == 1 || i == 15) begin
        chk($sformatf("t_w%0d_ren", i), 64'(ram_REN), 1);
        chk($sformatf("t_w%0d_err", i), 64'(err), 0);
      end
      chk($sformatf("t_w%0d_dhit", i), 64'(dhit), 0);
    end
    cyc(); dREN = 0; #1;
    chk("t_w16_ren", 64'(ram_REN), 0);
    chk("t_w16_err", 64'(err), 1);
    cyc(); #1;
    chk("t_w17_err", 64'(err), 1);
    chk("t_w17_ren", 64'(ram_REN), 0);
    chk("t_sb_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
